prog_run_ctrl: RTL and testbench

//  Synthesizable program-run sequencer for the single-cycle CPU: holds core in reset, loads IM then DM

---
 rtl/prog_run_pkg.sv | 24 ++
 rtl/prog_run_ctrl_run_timer.sv | 71 +++++++
 rtl/prog_run_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_prog_run_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_run_pkg.sv
// Shared types and default parameters for the program-run sequencer.
// No ports; imported by prog_run_ctrl and run_timer.
package prog_run_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IM,
    LOAD_DM,
    HOLD,
    RUN,
    DUMP_RD,
    DUMP_OUT,
    DONE
  } state_t;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_IM_AW      = 10;
  localparam int DEF_DM_AW      = 12;
  localparam int DEF_RST_HOLD   = 2;
  localparam int DEF_RUN_CYCLES = 4000;
  localparam int DEF_DUMP_WORDS = 40;
  localparam int DEF_HALT_WIN   = 8;

endpackage

// File: rtl/prog_run_ctrl_run_timer.sv
// RUN-phase timer: saturating run_cnt, run_end after RUN_CYCLES cycles
// (or on a stuck PC when HALT_DETECT_EN is defined). Ports: clk, rst, clr, en, core_pc, run_end, run_cnt.
module run_timer
  import prog_run_pkg::*;
#(
  parameter int RUN_CYCLES = DEF_RUN_CYCLES,
  parameter int HALT_WIN   = DEF_HALT_WIN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] core_pc,
  output logic        run_end,
  output logic [31:0] run_cnt
);

  localparam logic [31:0] LAST = 32'(RUN_CYCLES - 1);

  logic cyc_end;
  logic halt_end;

  // run_cnt counts completed cycles, so this cycle is the last one
  assign cyc_end = en && (run_cnt >= LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
    end else if (clr) begin
      run_cnt <= '0;
    end else if (en && (run_cnt != '1)) begin
      run_cnt <= run_cnt + 32'd1;
    end
  end

`ifdef HALT_DETECT_EN
  localparam logic [15:0] WIN_LAST = 16'(HALT_WIN - 1);

  logic [31:0] prev_pc;
  logic        pc_ok;
  logic [15:0] eq_cnt;
  logic        same;

  // first RUN cycle only captures the PC
  assign same     = pc_ok && (core_pc == prev_pc);
  assign halt_end = en && same && (eq_cnt >= WIN_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_pc <= '0;
      pc_ok   <= 1'b0;
      eq_cnt  <= '0;
    end else if (!en) begin
      pc_ok   <= 1'b0;
      eq_cnt  <= '0;
    end else begin
      prev_pc <= core_pc;
      pc_ok   <= 1'b1;
      eq_cnt  <= same ? eq_cnt + 16'd1 : 16'd0;
    end
  end
`else
  logic [31:0] unused_pc;
  localparam int unused_win = HALT_WIN;
  assign unused_pc = core_pc;
  assign halt_end  = 1'b0;
`endif

  assign run_end = cyc_end | halt_end;

endmodule

// File: rtl/prog_run_ctrl.sv
// Program-run sequencer: load IM then DM from a valid/ready stream, hold core reset, run, dump DM.
// Ports: start, ld_* load stream, im_*/dm_* memory side, core_rst/core_pc, dump_* stream, status. Option: HALT_DETECT_EN.
module prog_run_ctrl
  import prog_run_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int IM_AW      = DEF_IM_AW,
  parameter int DM_AW      = DEF_DM_AW,
  parameter int RST_HOLD   = DEF_RST_HOLD,
  parameter int RUN_CYCLES = DEF_RUN_CYCLES,
  parameter int DUMP_WORDS = DEF_DUMP_WORDS,
  parameter int HALT_WIN   = DEF_HALT_WIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              im_we,
  output logic [IM_AW-1:0]  im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              dm_we,
  output logic              dm_re,
  output logic [DM_AW-1:0]  dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              core_rst,
  input  logic [31:0]       core_pc,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [DM_AW-1:0]  dump_addr,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic              load_err,
  output logic [31:0]       run_cnt
);

  localparam logic [DM_AW-1:0] LAST_K    = DM_AW'(DUMP_WORDS - 1);
  localparam logic [31:0]      HOLD_INIT = 32'(RST_HOLD);

  state_t            state;
  state_t            nstate;
  logic [IM_AW-1:0]  im_la;
  logic              im_full;
  logic [DM_AW-1:0]  dm_la;
  logic              dm_full;
  logic [DM_AW-1:0]  k;
  logic [31:0]       hold_cnt;
  logic [DATA_W-1:0] dump_q;
  logic              fresh;
  logic              err_q;
  logic              beat;
  logic              start_ok;
  logic              run_end;

  assign beat     = ld_valid && ld_ready;
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  run_timer #(
    .RUN_CYCLES (RUN_CYCLES),
    .HALT_WIN   (HALT_WIN)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_ok),
    .en      (state == RUN),
    .core_pc (core_pc),
    .run_end (run_end),
    .run_cnt (run_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE, DONE: if (start) nstate = LOAD_IM;
      LOAD_IM:    if (beat && ld_last) nstate = LOAD_DM;
      LOAD_DM:    if (beat && ld_last) nstate = HOLD;
      HOLD:       if (hold_cnt <= 32'd1) nstate = RUN;
      RUN:        if (run_end) nstate = DUMP_RD;
      DUMP_RD:    nstate = DUMP_OUT;
      DUMP_OUT:   if (dump_ready) nstate = (k == LAST_K) ? DONE : DUMP_RD;
      default:    nstate = IDLE;
    endcase
  end

  always_comb begin
    ld_ready   = 1'b0;
    im_we      = 1'b0;
    dm_we      = 1'b0;
    dm_re      = 1'b0;
    dm_addr    = dm_la;
    dump_valid = 1'b0;
    dump_last  = 1'b0;
    core_rst   = 1'b1;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      IDLE: busy = 1'b0;
      LOAD_IM: begin
        ld_ready = 1'b1;
        im_we    = ld_valid && !im_full;
      end
      LOAD_DM: begin
        ld_ready = 1'b1;
        dm_we    = ld_valid && !dm_full;
      end
      HOLD: ;
      RUN: core_rst = 1'b0;
      DUMP_RD: begin
        dm_re   = 1'b1;
        dm_addr = k;
      end
      DUMP_OUT: begin
        dm_addr    = k;
        dump_valid = 1'b1;
        dump_last  = (k == LAST_K);
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign im_addr   = im_la;
  assign im_wdata  = ld_data;
  assign dm_wdata  = ld_data;
  assign dump_addr = k;
  assign load_err  = err_q;
  // memory data is only guaranteed the cycle after dm_re
  assign dump_data = fresh ? dm_rdata : dump_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_la    <= '0;
      im_full  <= 1'b0;
      dm_la    <= '0;
      dm_full  <= 1'b0;
      err_q    <= 1'b0;
      k        <= '0;
      hold_cnt <= '0;
      dump_q   <= '0;
      fresh    <= 1'b0;
    end else begin
      fresh <= (state == DUMP_RD);
      if ((state == DUMP_OUT) && fresh) dump_q <= dm_rdata;
      if (start_ok) begin
        im_la   <= '0;
        im_full <= 1'b0;
        dm_la   <= '0;
        dm_full <= 1'b0;
        err_q   <= 1'b0;
      end
      // address sticks at depth-1; later beats are dropped
      if ((state == LOAD_IM) && beat) begin
        if (im_full)      err_q   <= 1'b1;
        else if (&im_la)  im_full <= 1'b1;
        else              im_la   <= im_la + 1'b1;
      end
      if ((state == LOAD_DM) && beat) begin
        if (dm_full)      err_q   <= 1'b1;
        else if (&dm_la)  dm_full <= 1'b1;
        else              dm_la   <= dm_la + 1'b1;
      end
      if ((state == LOAD_DM) && beat && ld_last) hold_cnt <= HOLD_INIT;
      else if (state == HOLD)                    hold_cnt <= hold_cnt - 32'd1;
      if (state == RUN) k <= '0;
      else if ((state == DUMP_OUT) && dump_ready && (k != LAST_K)) k <= k + 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Self-checking bench for prog_run_ctrl: load, hold, run, dump, overflow, reset abort.
// Small DM model in the bench; halt-detect step only when HALT_DETECT_EN is defined.
module tb_prog_run_ctrl;

  localparam int DATA_W     = 32;
  localparam int IM_AW      = 2;
  localparam int DM_AW      = 3;
  localparam int RST_HOLD   = 2;
  localparam int DUMP_WORDS = 4;
  localparam int HALT_WIN   = 8;
`ifdef HALT_DETECT_EN
  localparam int RUN_CYC    = 20;
`else
  localparam int RUN_CYC    = 5;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              im_we;
  logic [IM_AW-1:0]  im_addr;
  logic [DATA_W-1:0] im_wdata;
  logic              dm_we;
  logic              dm_re;
  logic [DM_AW-1:0]  dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata = '0;
  logic              core_rst;
  logic [31:0]       core_pc = '0;
  logic              dump_valid;
  logic              dump_ready = 1'b0;
  logic [DATA_W-1:0] dump_data;
  logic [DM_AW-1:0]  dump_addr;
  logic              dump_last;
  logic              busy;
  logic              done;
  logic              load_err;
  logic [31:0]       run_cnt;

  prog_run_ctrl #(
    .DATA_W     (DATA_W),
    .IM_AW      (IM_AW),
    .DM_AW      (DM_AW),
    .RST_HOLD   (RST_HOLD),
    .RUN_CYCLES (RUN_CYC),
    .DUMP_WORDS (DUMP_WORDS),
    .HALT_WIN   (HALT_WIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .dm_we      (dm_we),
    .dm_re      (dm_re),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .core_rst   (core_rst),
    .core_pc    (core_pc),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_addr  (dump_addr),
    .dump_last  (dump_last),
    .busy       (busy),
    .done       (done),
    .load_err   (load_err),
    .run_cnt    (run_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [8] = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003,
                           32'hC0DE0004, 32'hC0DE0005, 32'hC0DE0006, 32'hC0DE0007};
  logic [31:0] exp_mem [8] = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003,
                               32'hC0DE0004, 32'hC0DE0005, 32'hC0DE0006, 32'hC0DE0007};

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_wdata;
    if (dm_re) dm_rdata <= mem[dm_addr];
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t wq[$];
  wr_t dq[$];
  int  tests_run = 0;
  int  tests_failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_image(input bit is_im, input int n, input logic [31:0] base, input bit gap);
    int depth;
    depth = is_im ? 4 : 8;
    wq.delete();
    for (int i = 0; i < n; i++) begin
      wr_t e;
      bit  wr;
      logic we_o;
      logic we_x;
      logic [31:0] a_o;
      wr = (i < depth);
      if (gap && (i == 1)) begin
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        chk("gap_we", 64'(is_im ? im_we : dm_we), 64'(0));
      end
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = base + i;
      ld_last  = (i == n - 1);
      if (wr) begin
        e.addr = i;
        e.data = base + i;
        wq.push_back(e);
        if (!is_im) exp_mem[i] = base + i;
      end
      #1;
      we_o = is_im ? im_we : dm_we;
      we_x = is_im ? dm_we : im_we;
      a_o  = is_im ? 32'(im_addr) : 32'(dm_addr);
      chk("ld_ready", 64'(ld_ready), 64'(1));
      chk("we", 64'(we_o), 64'(wr));
      chk("other_we", 64'(we_x), 64'(0));
      if (we_o && (wq.size() > 0)) begin
        e = wq.pop_front();
        chk("wr_addr", 64'(a_o), 64'(e.addr));
        chk("wr_data", 64'(is_im ? im_wdata : dm_wdata), 64'(e.data));
      end
      if (i >= depth) chk("load_err_ovf", 64'(load_err), 64'(i > depth));
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic run_phase(input bit halt_pat, input int exp_len);
    int h = 0;
    int n = 0;
    int g = 0;
    while (core_rst && (g < 50)) begin
      h++;
      g++;
      @(negedge clk);
    end
    chk("hold_len", 64'(h), 64'(RST_HOLD));
    g = 0;
    while (!core_rst && (g < 200)) begin
      n++;
      g++;
      core_pc = (halt_pat && (n >= 3)) ? 32'h40 : 32'(n * 4);
      @(negedge clk);
    end
    chk("run_len", 64'(n), 64'(exp_len));
    chk("run_cnt", 64'(run_cnt), 64'(exp_len));
    chk("dump_rd_re", 64'(dm_re), 64'(1));
    chk("dump_rd_addr", 64'(dm_addr), 64'(0));
  endtask

  task automatic dump_phase();
    int words = 0;
    int g = 0;
    wr_t e;
    dq.delete();
    for (int a = 0; a < DUMP_WORDS; a++) begin
      e.addr = a;
      e.data = exp_mem[a];
      dq.push_back(e);
    end
    dump_ready = 1'b0;
    while (!done && (g < 100)) begin
      dump_ready = ~dump_ready;
      #1;
      if (dump_valid && dump_ready) begin
        if (dq.size() == 0) begin
          chk("dump_extra", 64'(1), 64'(0));
        end else begin
          e = dq.pop_front();
          chk("dump_addr", 64'(dump_addr), 64'(e.addr));
          chk("dump_data", 64'(dump_data), 64'(e.data));
          chk("dump_last", 64'(dump_last), 64'(e.addr == DUMP_WORDS - 1));
        end
        words++;
      end
      g++;
      @(negedge clk);
    end
    dump_ready = 1'b0;
    chk("dump_words", 64'(words), 64'(DUMP_WORDS));
    chk("done", 64'(done), 64'(1));
    chk("done_busy", 64'(busy), 64'(0));
    chk("done_core_rst", 64'(core_rst), 64'(1));
    chk("done_valid", 64'(dump_valid), 64'(0));
  endtask

  initial begin
    int g;
    repeat (2) @(negedge clk);
    chk("rst_core_rst", 64'(core_rst), 64'(1));
    chk("rst_ld_ready", 64'(ld_ready), 64'(0));
    chk("rst_strobes", 64'({im_we, dm_we, dm_re}), 64'(0));
    chk("rst_dump", 64'({dump_valid, dump_last}), 64'(0));
    chk("rst_status", 64'({busy, done, load_err}), 64'(0));
    chk("rst_addrs", 64'({im_addr, dm_addr}), 64'(0));
    chk("rst_run_cnt", 64'(run_cnt), 64'(0));
    rst = 1'b0;

    start_pulse();
    chk("load_busy", 64'(busy), 64'(1));
    load_image(1'b1, 3, 32'hA000_0000, 1'b1);
    load_image(1'b0, 2, 32'hD000_0000, 1'b0);
    chk("hold_ld_ready", 64'(ld_ready), 64'(0));
    run_phase(1'b0, RUN_CYC);
    dump_phase();

    start_pulse();
    chk("start_clr_cnt", 64'(run_cnt), 64'(0));
    load_image(1'b1, 6, 32'hB000_0000, 1'b0);
    chk("err_after_im", 64'(load_err), 64'(1));
    load_image(1'b0, 1, 32'hE000_0000, 1'b0);
    run_phase(1'b0, RUN_CYC);
    dump_phase();
    chk("err_sticky", 64'(load_err), 64'(1));

    start_pulse();
    chk("start_clr_err", 64'(load_err), 64'(0));
    load_image(1'b1, 1, 32'hA100_0000, 1'b0);
    load_image(1'b0, 1, 32'hD100_0000, 1'b0);
    g = 0;
    while (core_rst && (g < 20)) begin
      g++;
      @(negedge clk);
    end
    chk("in_run", 64'(core_rst), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_run_core_rst", 64'(core_rst), 64'(1));
    chk("abort_run_busy", 64'(busy), 64'(0));
    chk("abort_run_cnt", 64'(run_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    start_pulse();
    load_image(1'b1, 1, 32'hA200_0000, 1'b0);
    load_image(1'b0, 1, 32'hD200_0000, 1'b0);
    run_phase(1'b0, RUN_CYC);
    dump_ready = 1'b0;
    g = 0;
    while (!dump_valid && (g < 10)) begin
      g++;
      @(negedge clk);
    end
    chk("in_dump_out", 64'(dump_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("abort_dump_valid", 64'(dump_valid), 64'(0));
    chk("abort_dump_core_rst", 64'(core_rst), 64'(1));
    chk("abort_dump_re", 64'(dm_re), 64'(0));
    chk("abort_dump_done", 64'(done), 64'(0));
    @(negedge clk);
    rst = 1'b0;

`ifdef HALT_DETECT_EN
    start_pulse();
    load_image(1'b1, 1, 32'hA300_0000, 1'b0);
    load_image(1'b0, 1, 32'hD300_0000, 1'b0);
    run_phase(1'b1, 11);
    dump_phase();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

endmodule
